access_arbiter: RTL

ACCESS_ARBITER -- requirements
Module: access_arbiter

---
 rtl/access_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/access_arbiter.sv
// Round-robin N-input arbiter with burst lock and one registered output slot.
// The slot refills on the same edge it drains, so back-to-back beats flow without bubbles.
module access_arbiter #(
    parameter int N_INPUTS   = 8,
    parameter int DATA_WIDTH = 128,
    parameter int IDX_W      = 3,
    parameter int MAX_BURST  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_INPUTS-1:0]            req_valid,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] req_data,
    output logic [N_INPUTS-1:0]            req_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]               out_idx,
    input  logic                           out_ready,
    output logic                           active,
    output logic [15:0]                    conflict_cnt
);

    if (N_INPUTS < 2 || N_INPUTS > 16) begin : g_bad_n
        $error("access_arbiter: N_INPUTS must be in 2..16");
    end
    if ((1 << IDX_W) < N_INPUTS) begin : g_bad_idx
        $error("access_arbiter: IDX_W too narrow for N_INPUTS");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("access_arbiter: MAX_BURST must be in 1..15");
    end

    localparam logic [IDX_W:0]   N_L      = (IDX_W+1)'(N_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic [3:0]       MB_L     = 4'(MAX_BURST);

    logic [IDX_W-1:0]      r_ptr;
    logic [3:0]            r_bcnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [IDX_W-1:0]      r_out_idx;
    logic [15:0]           r_conflict;

    logic                  w_open;
    logic                  w_accept;
    logic                  w_multi;
    logic                  w_ptr_valid;
    logic [2*N_INPUTS-1:0] w_dbl;
    logic [N_INPUTS-1:0]   w_rot;
    logic [IDX_W-1:0]      w_off;
    logic [IDX_W:0]        w_sum;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_next;
    logic [3:0]            w_bcnt_new;
    logic [DATA_WIDTH-1:0] w_pay [N_INPUTS];

    // Rotate so the search always starts at bit 0, then map the offset back.
    assign w_dbl = {req_valid, req_valid} >> r_ptr;
    assign w_rot = w_dbl[N_INPUTS-1:0];

    always_comb begin
        w_off = '0;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win       = (w_sum >= N_L) ? IDX_W'(w_sum - N_L) : IDX_W'(w_sum);
    assign w_next      = (w_win == LAST_IDX) ? '0 : w_win + IDX_W'(1);
    assign w_ptr_valid = req_valid[r_ptr];
    // A valid lock holder always wins the search, so it extends its run; anyone else starts fresh.
    assign w_bcnt_new  = w_ptr_valid ? r_bcnt + 4'd1 : 4'd1;

    assign w_open   = ~r_out_valid | out_ready;
    assign w_accept = rst_n & w_open & (|req_valid);
    assign w_multi  = |(req_valid & (req_valid - N_INPUTS'(1)));

    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_lane
        assign w_pay[gi]     = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign req_ready[gi] = w_accept & (w_win == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_bcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_conflict  <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pay[w_win];
                r_out_idx   <= w_win;
                if (w_bcnt_new == MB_L) begin
                    r_ptr  <= w_next;
                    r_bcnt <= '0;
                end else begin
                    r_ptr  <= w_win;
                    r_bcnt <= w_bcnt_new;
                end
                if (w_multi && r_conflict != 16'hFFFF) begin
                    r_conflict <= r_conflict + 16'd1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_idx      = r_out_idx;
    assign conflict_cnt = r_conflict;
    assign active       = (|req_valid) | r_out_valid;

endmodule
